stickman_motion: RTL and testbench
==================================

// Module: stickman_motion
// PURPOSE
// - Vertical physics for the stickman: jump on SPACE, gravity, landing, walking off ledges.
// - Produces StickmanBottom, which the game-status FSM compares against GroundY.
//   That FSM declares a crash when StickmanBottom > GroundY+50 and a fall when StickmanBottom >= 470.
// - Updates once per frame_clk rising edge and only while status = PLAY.
// - Consumes game status (one-hot {WAIT,PLAY,WIN,LOSE}) from the game-status FSM.
// PARAMETERS
// START_Y      10'd400  bottom row at reset / while WAIT
// JUMP_V       -6'sd12  initial vertical velocity on jump (px/frame, negative = up)
// GRAVITY      6'sd1    velocity increment per frame while airborne
// MAX_FALL_V   6'sd15   downward velocity saturation
// STEP_UP      10'd8    max ground rise absorbed by snapping while grounded
// BOTTOM_LIMIT 10'd479  lowest legal StickmanBottom (screen bottom)
// PORTS
// Clk             in   1   50 MHz system clock
// Reset           in   1   synchronous, active-high
// frame_clk       in   1   ~60 Hz frame strobe (level), synchronous to Clk
// keycode         in   8   last received key; 8'h2c = SPACE
// GroundY         in   10  ground row under the stickman this frame
// status          in   4   {wait,play,win,lose} one-hot from the game-status FSM
// StickmanBottom  out  10  bottom row of the stickman
// airborne        out  1   1 when state is RISING or FALLING
// RATIONALE: one clock; reset is synchronous and active-high (Clk, Reset).
// BEHAVIOUR
// - Reset: StickmanBottom=START_Y, vel=0, state=GROUNDED, airborne=0, jump_req=0, frame_prev=0.
// - frame_tick = frame_clk & ~frame_prev (1-cycle pulse). All physics updates happen only on frame_tick.
//   Outputs are registered and change in the cycle after frame_tick.
// - jump_req: set when keycode becomes 8'h2c (edge, previous cycle != 8'h2c); cleared on every frame_tick.
//   Holding SPACE never re-triggers.
// - status=WAIT: every frame_tick, force START_Y, vel 0, GROUNDED.
//   status=WIN/LOSE/0000: freeze all state.
// - status=PLAY, per frame_tick, by state (vel signed 6b, math in signed 11b):
//   GROUNDED:
//     * if jump_req: vel<=JUMP_V, ->RISING, position unchanged this frame.
//     * else if GroundY > bottom: vel<=0, ->FALLING (walk off ledge / pit).
//     * else if bottom-GroundY <= STEP_UP: bottom<=GroundY.
//     * else: hold (wall; crash is judged downstream).
//   RISING/FALLING:
//     * nxt = bottom + vel; vel <= min(vel+GRAVITY, MAX_FALL_V).
//     * if nxt < 0: bottom<=0, vel<=0.
//     * landing: vel>=0 and bottom<=GroundY and nxt>=GroundY -> bottom<=GroundY, vel<=0, ->GROUNDED.
//     * else if nxt > BOTTOM_LIMIT: bottom<=BOTTOM_LIMIT, stay FALLING.
//     * else bottom<=nxt.
//     * RISING->FALLING when updated vel >= 0.
//   - A jump_req during RISING/FALLING is discarded (no double jump).
// - Landing takes priority over the BOTTOM_LIMIT clamp when both apply.
// - Reset mid-jump returns to the reset values on the next edge.
// STRUCTURE
// - stickman_pkg: motion_state_t {GROUNDED,RISING,FALLING};
//   KEY_SPACE=8'h2c; ST_WAIT=4'b1000, ST_PLAY=4'b0100, ST_WIN=4'b0010, ST_LOSE=4'b0001.
//   The game-status FSM shares these constants.
// - Sub-module frame_tick_gen (frame_clk rising-edge pulse), reusable by scroller/score blocks.
// - Remainder: one always_ff state/velocity/position register block + one always_comb next-state block.
// TESTING
// 1 Reset, status=PLAY, GroundY=400, no key, 5 frames -> bottom=400, airborne=0 throughout.
// 2 Jump: GroundY=400, pulse keycode 2c then 00 -> jump frame holds 400;
//   after 12 further frames bottom=322 (apex);
//   after 25 frames after the jump frame bottom=400, GROUNDED, airborne=0.
// 3 Hold keycode=2c for 60 frames -> exactly one jump; back on ground at 400 and stays.
// 4 Pit: grounded at 400, GroundY->479 -> FALLING, v=0,1,2..;
//   bottom reaches 479 and clamps, never exceeds 479.
// 5 Step/wall: grounded at 400, GroundY=395 -> bottom=395 next frame;
//   GroundY=380 -> bottom holds 395.
// 6 Freeze/reset: mid-jump set status=LOSE -> bottom/vel frozen;
//   status=WAIT -> bottom=400 next frame; Reset mid-jump -> 400, GROUNDED next cycle.

Source files
------------

// File: rtl/stickman_pkg.sv
// stickman_pkg
// Shared types and constants for the stickman blocks. The game-status FSM
// uses the same status encodings and key code, so any change here must be
// mirrored there.
//   motion_state_t : vertical motion state of the stickman
//   KEY_SPACE      : PS/2 make code for the space bar
//   ST_*           : one-hot game status {WAIT,PLAY,WIN,LOSE}
//   START_Y .. BOTTOM_LIMIT : physics tuning constants (rows and px/frame)
package stickman_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } motion_state_t;

  localparam logic [7:0] KEY_SPACE = 8'h2c;

  localparam logic [3:0] ST_WAIT = 4'b1000;
  localparam logic [3:0] ST_PLAY = 4'b0100;
  localparam logic [3:0] ST_WIN  = 4'b0010;
  localparam logic [3:0] ST_LOSE = 4'b0001;

  localparam logic        [9:0] START_Y      = 10'd400;
  localparam logic signed [5:0] JUMP_V       = -6'sd12;
  localparam logic signed [5:0] GRAVITY      = 6'sd1;
  localparam logic signed [5:0] MAX_FALL_V   = 6'sd15;
  localparam logic        [9:0] STEP_UP      = 10'd8;
  localparam logic        [9:0] BOTTOM_LIMIT = 10'd479;

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen
// Turns the level-type frame strobe into a single-cycle pulse on its rising
// edge. frame_clk is already synchronous to Clk, so no synchroniser is used.
// Ports:
//   Clk        in  system clock
//   Reset      in  synchronous, active-high
//   frame_clk  in  ~60 Hz frame strobe (level)
//   frame_tick out one-Clk pulse on each frame_clk rising edge
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic frame_prev;

  // Remember last cycle's strobe level for edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_prev <= 1'b0;
    end else begin
      frame_prev <= frame_clk;
    end
  end

  assign frame_tick = frame_clk & ~frame_prev;

endmodule

// File: rtl/stickman_motion.sv
// stickman_motion
// Vertical physics of the stickman: jump on SPACE, gravity, landing on the
// ground, snapping up small steps and walking off ledges. Updates once per
// frame while the game is in PLAY; held at the start row in WAIT and frozen
// in WIN/LOSE.
// Ports:
//   Clk            in  50 MHz system clock
//   Reset          in  synchronous, active-high
//   frame_clk      in  frame strobe (level), synchronous to Clk
//   keycode        in  last received key code
//   GroundY        in  ground row under the stickman this frame
//   status         in  one-hot game status {WAIT,PLAY,WIN,LOSE}
//   StickmanBottom out bottom row of the stickman (registered)
//   airborne       out high while RISING or FALLING
module stickman_motion
  import stickman_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] GroundY,
  input  logic [3:0] status,
  output logic [9:0] StickmanBottom,
  output logic       airborne
);

  motion_state_t     state, state_nxt;
  logic signed [5:0] vel, vel_nxt;
  logic [9:0]        bottom_nxt;
  logic [7:0]        key_prev;
  logic              jump_req, jump_req_nxt;
  logic              key_edge;
  logic              frame_tick;

  logic signed [10:0] pos_s;
  logic signed [10:0] ground_s;
  logic signed [10:0] nxt_pos;
  logic signed [6:0]  vel_inc;
  logic signed [5:0]  vel_grav;
  logic               landing;

  frame_tick_gen u_frame_tick_gen (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  // State, velocity and position only move on frame ticks (gated in the
  // next-state logic); key history and the jump request track every cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= GROUNDED;
      vel            <= 6'sd0;
      StickmanBottom <= START_Y;
      key_prev       <= 8'h00;
      jump_req       <= 1'b0;
    end else begin
      state          <= state_nxt;
      vel            <= vel_nxt;
      StickmanBottom <= bottom_nxt;
      key_prev       <= keycode;
      jump_req       <= jump_req_nxt;
    end
  end

  // Next-state physics. Arithmetic is done in signed 11 bits so that a jump
  // near the top of the screen can go negative and be caught.
  always_comb begin
    state_nxt  = state;
    vel_nxt    = vel;
    bottom_nxt = StickmanBottom;

    key_edge = (keycode == KEY_SPACE) && (key_prev != KEY_SPACE);
    // A space press landing on the tick cycle is kept for the next frame
    // rather than lost.
    jump_req_nxt = frame_tick ? key_edge : (jump_req | key_edge);

    pos_s    = signed'({1'b0, StickmanBottom});
    ground_s = signed'({1'b0, GroundY});
    nxt_pos  = pos_s + 11'(vel);
    vel_inc  = 7'(vel) + 7'(GRAVITY);
    vel_grav = (vel_inc > 7'(MAX_FALL_V)) ? MAX_FALL_V : vel_inc[5:0];
    landing  = (vel >= 6'sd0) && (StickmanBottom <= GroundY) &&
               (nxt_pos >= ground_s);

    if (frame_tick) begin
      case (status)
        ST_WAIT: begin
          state_nxt  = GROUNDED;
          vel_nxt    = 6'sd0;
          bottom_nxt = START_Y;
        end
        ST_PLAY: begin
          if (state == GROUNDED) begin
            if (jump_req) begin
              vel_nxt   = JUMP_V;
              state_nxt = RISING;
            end else if (GroundY > StickmanBottom) begin
              vel_nxt   = 6'sd0;
              state_nxt = FALLING;
            end else if ((StickmanBottom - GroundY) <= STEP_UP) begin
              bottom_nxt = GroundY;
            end
          end else begin
            // Landing is checked before the screen-bottom clamp so that
            // ground at the very bottom row still counts as ground.
            if (nxt_pos < 11'sd0) begin
              bottom_nxt = 10'd0;
              vel_nxt    = 6'sd0;
              state_nxt  = FALLING;
            end else if (landing) begin
              bottom_nxt = GroundY;
              vel_nxt    = 6'sd0;
              state_nxt  = GROUNDED;
            end else if (nxt_pos > signed'({1'b0, BOTTOM_LIMIT})) begin
              bottom_nxt = BOTTOM_LIMIT;
              vel_nxt    = vel_grav;
              state_nxt  = FALLING;
            end else begin
              bottom_nxt = nxt_pos[9:0];
              vel_nxt    = vel_grav;
              state_nxt  = (vel_grav >= 6'sd0) ? FALLING : RISING;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign airborne = (state != GROUNDED);

endmodule

// File: tb/tb_stickman_motion.sv
// tb_stickman_motion
// Directed bench for stickman_motion: reset, jump arc, held key, pit fall
// and screen-bottom clamp, step/wall handling, freeze/WAIT/reset mid-jump.
module tb_stickman_motion;
  import stickman_pkg::*;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic [9:0] GroundY;
  logic [3:0] status;
  logic [9:0] StickmanBottom;
  logic       airborne;

  int checks;
  int failures;

  stickman_motion dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_clk      (frame_clk),
    .keycode        (keycode),
    .GroundY        (GroundY),
    .status         (status),
    .StickmanBottom (StickmanBottom),
    .airborne       (airborne)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One frame: strobe high for a cycle, then low for two. Outputs are
  // sampled on the negedge after, well away from the active edge.
  task automatic do_frame();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk) Reset = 1'b0;
  endtask

  task automatic press_space();
    @(negedge Clk) keycode = KEY_SPACE;
    @(negedge Clk) keycode = 8'h00;
  endtask

  task automatic test_reset();
    status  = ST_PLAY;
    GroundY = 10'd400;
    keycode = 8'h00;
    do_reset();
    checks++;
    if (StickmanBottom !== 10'd400 || airborne !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state bottom=%0d airborne=%0b expected 400/0",
               StickmanBottom, airborne);
    end
    for (int i = 0; i < 5; i++) begin
      do_frame();
      checks++;
      if (StickmanBottom !== 10'd400 || airborne !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_frame%0d bottom=%0d airborne=%0b expected 400/0",
                 i, StickmanBottom, airborne);
      end
    end
  endtask

  task automatic test_jump();
    // Expected bottom after each frame following the jump frame.
    logic [9:0] arc [25] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325,
                             323, 322, 322, 323, 325, 328, 332, 337, 343, 350,
                             358, 367, 377, 388, 400};
    press_space();
    do_frame();
    checks++;
    if (StickmanBottom !== 10'd400 || airborne !== 1'b1) begin
      failures++;
      $display("[TB] FAIL jump_frame bottom=%0d airborne=%0b expected 400/1",
               StickmanBottom, airborne);
    end
    for (int i = 0; i < 25; i++) begin
      do_frame();
      checks++;
      if (StickmanBottom !== arc[i]) begin
        failures++;
        $display("[TB] FAIL jump_arc_f%0d bottom=%0d expected %0d",
                 i + 1, StickmanBottom, arc[i]);
      end
    end
    checks++;
    if (airborne !== 1'b0) begin
      failures++;
      $display("[TB] FAIL jump_landed airborne=%0b expected 0", airborne);
    end
  endtask

  task automatic test_hold_space();
    int   jumps;
    logic prev_air;
    jumps    = 0;
    prev_air = airborne;
    @(negedge Clk) keycode = KEY_SPACE;
    for (int i = 0; i < 60; i++) begin
      do_frame();
      if (airborne && !prev_air) jumps++;
      prev_air = airborne;
    end
    keycode = 8'h00;
    checks++;
    if (jumps !== 1) begin
      failures++;
      $display("[TB] FAIL hold_jump_count got=%0d expected 1", jumps);
    end
    checks++;
    if (StickmanBottom !== 10'd400 || airborne !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_end bottom=%0d airborne=%0b expected 400/0",
               StickmanBottom, airborne);
    end
  endtask

  task automatic test_pit();
    logic [9:0] max_bottom;
    max_bottom = 10'd0;
    GroundY = 10'd479;
    do_frame();
    checks++;
    if (StickmanBottom !== 10'd400 || airborne !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pit_start bottom=%0d airborne=%0b expected 400/1",
               StickmanBottom, airborne);
    end
    for (int i = 2; i <= 15; i++) begin
      do_frame();
      if (StickmanBottom > max_bottom) max_bottom = StickmanBottom;
      if (i == 14) begin
        checks++;
        if (StickmanBottom !== 10'd478) begin
          failures++;
          $display("[TB] FAIL pit_f14 bottom=%0d expected 478", StickmanBottom);
        end
      end
    end
    checks++;
    if (StickmanBottom !== 10'd479 || airborne !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pit_land bottom=%0d airborne=%0b expected 479/0",
               StickmanBottom, airborne);
    end
    // Ground below the screen: fall is clamped at the bottom row.
    GroundY = 10'd600;
    for (int i = 0; i < 4; i++) begin
      do_frame();
      if (StickmanBottom > max_bottom) max_bottom = StickmanBottom;
    end
    checks++;
    if (StickmanBottom !== 10'd479 || airborne !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pit_clamp bottom=%0d airborne=%0b expected 479/1",
               StickmanBottom, airborne);
    end
    checks++;
    if (max_bottom > 10'd479) begin
      failures++;
      $display("[TB] FAIL pit_max bottom=%0d expected <=479", max_bottom);
    end
  endtask

  task automatic test_step_wall();
    GroundY = 10'd400;
    do_reset();
    GroundY = 10'd395;
    do_frame();
    checks++;
    if (StickmanBottom !== 10'd395 || airborne !== 1'b0) begin
      failures++;
      $display("[TB] FAIL step_up bottom=%0d airborne=%0b expected 395/0",
               StickmanBottom, airborne);
    end
    GroundY = 10'd380;
    do_frame();
    checks++;
    if (StickmanBottom !== 10'd395) begin
      failures++;
      $display("[TB] FAIL wall_hold bottom=%0d expected 395", StickmanBottom);
    end
    GroundY = 10'd387;
    do_frame();
    checks++;
    if (StickmanBottom !== 10'd387) begin
      failures++;
      $display("[TB] FAIL step_max bottom=%0d expected 387", StickmanBottom);
    end
  endtask

  task automatic test_freeze_reset();
    GroundY = 10'd400;
    do_reset();
    press_space();
    do_frame();
    for (int i = 0; i < 4; i++) do_frame();
    checks++;
    if (StickmanBottom !== 10'd358) begin
      failures++;
      $display("[TB] FAIL freeze_pre bottom=%0d expected 358", StickmanBottom);
    end
    status = ST_LOSE;
    for (int i = 0; i < 3; i++) do_frame();
    checks++;
    if (StickmanBottom !== 10'd358 || airborne !== 1'b1) begin
      failures++;
      $display("[TB] FAIL freeze_hold bottom=%0d airborne=%0b expected 358/1",
               StickmanBottom, airborne);
    end
    // Velocity was frozen at -8, so play resumes from there.
    status = ST_PLAY;
    do_frame();
    checks++;
    if (StickmanBottom !== 10'd350) begin
      failures++;
      $display("[TB] FAIL freeze_resume bottom=%0d expected 350", StickmanBottom);
    end
    status = ST_WAIT;
    do_frame();
    checks++;
    if (StickmanBottom !== 10'd400 || airborne !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wait_force bottom=%0d airborne=%0b expected 400/0",
               StickmanBottom, airborne);
    end
    status = ST_PLAY;
    press_space();
    for (int i = 0; i < 4; i++) do_frame();
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (StickmanBottom !== 10'd400 || airborne !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_midjump bottom=%0d airborne=%0b expected 400/0",
               StickmanBottom, airborne);
    end
    Reset = 1'b0;
    do_frame();
    checks++;
    if (StickmanBottom !== 10'd400 || airborne !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_reset bottom=%0d airborne=%0b expected 400/0",
               StickmanBottom, airborne);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    Reset     = 1'b1;
    frame_clk = 1'b0;
    keycode   = 8'h00;
    GroundY   = 10'd400;
    status    = ST_PLAY;
    test_reset();
    test_jump();
    test_hold_space();
    test_pit();
    test_step_wall();
    test_freeze_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
